// File: rtl/window_fetch_ctrl.sv
// window_fetch_ctrl
// Read-side sequencer for the frame BRAM. Once the frame is fully written it
// walks every 3x3 neighbourhood in raster order. It issues one tap coordinate
// per cycle and gathers the nine returned pixels into one packed window word.
// The window word is then offered downstream over a valid/ready handshake.
//
// Build option: define WIN_ZERO_PAD_EN to produce a window for every pixel.
// Taps outside the image then read as zero. Without it, only interior
// centres are produced, and frames narrower or shorter than 3 finish at once.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   start             begin one frame pass (honoured in IDLE only)
//   H, W              image height / width, latched on accepted start
//   all_loaded        frame RAM write complete
//   rd_data           pixel returned by the RAM, RD_LAT cycles after address
//   read_H, read_W    registered tap address to the RAM
//   win_valid         window word available
//   win_ready         downstream accepts the window
//   win_data          nine taps, tap0 (top-left) in the low slice
//   win_row, win_col  centre of the presented window
//   busy              high outside IDLE
//   done              one-cycle pulse after the last window is accepted
module window_fetch_ctrl #(
  parameter int DATA_W = 8,
  parameter int DIM_W  = 16,
  parameter int RD_LAT = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DIM_W-1:0]    H,
  input  logic [DIM_W-1:0]    W,
  input  logic                all_loaded,
  input  logic [DATA_W-1:0]   rd_data,
  output logic [DIM_W-1:0]    read_H,
  output logic [DIM_W-1:0]    read_W,
  output logic                win_valid,
  input  logic                win_ready,
  output logic [9*DATA_W-1:0] win_data,
  output logic [DIM_W-1:0]    win_row,
  output logic [DIM_W-1:0]    win_col,
  output logic                busy,
  output logic                done
);

  localparam int EXT_W = DIM_W + 1;
  localparam int DCW   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(RD_LAT - 1);

`ifdef WIN_ZERO_PAD_EN
  localparam logic [DIM_W-1:0] CEN_FIRST = '0;
  localparam logic [EXT_W-1:0] EDGE_GAP  = EXT_W'(1);
`else
  localparam logic [DIM_W-1:0] CEN_FIRST = DIM_W'(1);
  localparam logic [EXT_W-1:0] EDGE_GAP  = EXT_W'(2);
`endif

  typedef enum logic [2:0] {IDLE, WAIT_LOAD, ISSUE, DRAIN, PRESENT, FINISH} state_t;

  state_t           state, state_n;
  logic [DIM_W-1:0] h_lat, w_lat;
  logic [DIM_W-1:0] cen_row, cen_col, cen_row_n, cen_col_n;
  logic [3:0]       tap_idx, tap_n;
  logic [DCW-1:0]   drain_cnt;
  logic             issue_n;
  logic             too_small;
  logic [EXT_W-1:0] row_inc, col_inc, row_max, col_max;
  logic [DIM_W-1:0] tap_r, tap_c;
  logic             tap_in_img;

  // Tag pipeline: stage i describes the tap whose address went out i cycles ago.
  logic [RD_LAT:0]  tag_vld;
  logic [RD_LAT:0]  tag_pad;
  logic [3:0]       tag_k [RD_LAT+1];

  function automatic logic [1:0] tap_dr(input logic [3:0] k);
    case (k)
      4'd0, 4'd1, 4'd2: tap_dr = 2'd0;
      4'd3, 4'd4, 4'd5: tap_dr = 2'd1;
      default:          tap_dr = 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] tap_dc(input logic [3:0] k);
    case (k)
      4'd0, 4'd3, 4'd6: tap_dc = 2'd0;
      4'd1, 4'd4, 4'd7: tap_dc = 2'd1;
      default:          tap_dc = 2'd2;
    endcase
  endfunction

  // One bit wider than a coordinate, so the edge compares cannot wrap.
  assign row_inc = {1'b0, cen_row} + EXT_W'(1);
  assign col_inc = {1'b0, cen_col} + EXT_W'(1);
  assign row_max = {1'b0, h_lat} - EDGE_GAP;
  assign col_max = {1'b0, w_lat} - EDGE_GAP;

`ifdef WIN_ZERO_PAD_EN
  assign too_small = (h_lat == '0) || (w_lat == '0);
`else
  assign too_small = (h_lat < DIM_W'(3)) || (w_lat < DIM_W'(3));
`endif

  always_comb begin
    state_n   = state;
    tap_n     = tap_idx;
    cen_row_n = cen_row;
    cen_col_n = cen_col;
    case (state)
      IDLE: begin
        if (start) begin
          state_n   = WAIT_LOAD;
          cen_row_n = CEN_FIRST;
          cen_col_n = CEN_FIRST;
        end
      end
      WAIT_LOAD: begin
        if (all_loaded) begin
          tap_n   = 4'd0;
          state_n = too_small ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        if (tap_idx == 4'd8) state_n = DRAIN;
        else                 tap_n   = tap_idx + 4'd1;
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_n = PRESENT;
      end
      PRESENT: begin
        if (win_ready) begin
          tap_n = 4'd0;
          if (col_inc > col_max) begin
            cen_col_n = CEN_FIRST;
            if (row_inc > row_max) begin
              state_n = FINISH;
            end else begin
              cen_row_n = row_inc[DIM_W-1:0];
              state_n   = ISSUE;
            end
          end else begin
            cen_col_n = col_inc[DIM_W-1:0];
            state_n   = ISSUE;
          end
        end
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The address register is loaded on the edge that enters each ISSUE cycle.
  // This puts tap k's address on the bus during ISSUE cycle k, built from the
  // centre that window will use.
  assign issue_n = (state_n == ISSUE);
  assign tap_r   = cen_row_n + DIM_W'(tap_dr(tap_n)) - DIM_W'(1);
  assign tap_c   = cen_col_n + DIM_W'(tap_dc(tap_n)) - DIM_W'(1);

`ifdef WIN_ZERO_PAD_EN
  logic [EXT_W-1:0] tap_r_ext, tap_c_ext;
  // These are the tap coordinates plus one, so 0 means "one before the edge".
  assign tap_r_ext  = {1'b0, cen_row_n} + EXT_W'(tap_dr(tap_n));
  assign tap_c_ext  = {1'b0, cen_col_n} + EXT_W'(tap_dc(tap_n));
  assign tap_in_img = (tap_r_ext != '0) && (tap_r_ext <= {1'b0, h_lat}) &&
                      (tap_c_ext != '0) && (tap_c_ext <= {1'b0, w_lat});
`else
  assign tap_in_img = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      h_lat     <= '0;
      w_lat     <= '0;
      cen_row   <= '0;
      cen_col   <= '0;
      tap_idx   <= '0;
      drain_cnt <= '0;
      read_H    <= '0;
      read_W    <= '0;
    end else begin
      state     <= state_n;
      cen_row   <= cen_row_n;
      cen_col   <= cen_col_n;
      tap_idx   <= tap_n;
      drain_cnt <= (state == DRAIN) ? drain_cnt + DCW'(1) : '0;
      if (state == IDLE && start) begin
        h_lat <= H;
        w_lat <= W;
      end
      // Out-of-image taps leave the address untouched so the RAM never sees it.
      if (issue_n && tap_in_img) begin
        read_H <= tap_r;
        read_W <= tap_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_vld <= '0;
      tag_pad <= '0;
    end else begin
      tag_vld <= {tag_vld[RD_LAT-1:0], issue_n};
      tag_pad <= {tag_pad[RD_LAT-1:0], ~tap_in_img};
    end
  end

  always_ff @(posedge clk) begin
    tag_k[0] <= tap_n;
    for (int i = 1; i <= RD_LAT; i++) tag_k[i] <= tag_k[i-1];
  end

  // The oldest tag lines up with the pixel now on rd_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_data <= '0;
    end else if (tag_vld[RD_LAT]) begin
      win_data[tag_k[RD_LAT]*DATA_W +: DATA_W] <= tag_pad[RD_LAT] ? '0 : rd_data;
    end
  end

  assign win_valid = (state == PRESENT);
  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);
  assign win_row   = cen_row;
  assign win_col   = cen_col;

endmodule
